// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the byte-strobed data memory controller.
package data_mem_pkg;

  typedef enum logic [2:0] {
    W  = 3'd0,
    H  = 3'd1,
    B  = 3'd2,
    HU = 3'd3,
    BU = 3'd4
  } mem_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } dm_state_e;

  // Lane mask for one access part: part 0 covers word index, part 1 covers index+1.
  function automatic logic [3:0] byte_strobe(mem_type_e t, logic [1:0] off, logic part);
    logic [7:0] m;
    case (t)
      W:       m = 8'h0F;
      H, HU:   m = 8'h03;
      default: m = 8'h01;
    endcase
    m = m << off;
    return part ? m[7:4] : m[3:0];
  endfunction

  function automatic logic is_spanning(mem_type_e t, logic [1:0] off);
    case (t)
      W:       return off != 2'd0;
      H, HU:   return off == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend(mem_type_e t, logic [31:0] raw);
    case (t)
      H:       return {{16{raw[15]}}, raw[15:0]};
      B:       return {{24{raw[7]}}, raw[7:0]};
      HU:      return {16'h0000, raw[15:0]};
      BU:      return {24'h000000, raw[7:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store unit and the data memory controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Synchronous-read word RAM with per-byte write enables; read data is registered.
module dmem_bank #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register carry no reset so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// Valid/ready data memory controller; word-crossing accesses are split over two RAM cycles.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS      = 256,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int IDX_W = ADDR_W - 2;

  dm_state_e   state_q, state_d;
  logic        we_q, err_q, span_q;
  mem_type_e   type_q;
  logic [1:0]  off_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q, hold_q;

  logic        ram_en;
  logic [3:0]  ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic            accept;
  mem_type_e       req_t;
  logic [1:0]      req_off;
  logic [IDX_W-1:0] req_idx;
  logic            req_span, req_err;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign req_t   = mem_type_e'(bus.req_type);
  assign req_off = bus.req_addr[1:0];
  assign req_idx = bus.req_addr[ADDR_W-1:2];
  assign req_span = is_spanning(req_t, req_off);

  // Spanning accesses never wrap to word 0, so the last word cannot start one.
  assign req_err = (bus.req_type > 3'd4)
                || (bus.req_we && (req_t == HU || req_t == BU))
                || (req_idx >= IDX_W'(DEPTH_WORDS))
                || (req_span && (req_idx >= IDX_W'(DEPTH_WORDS - 1)))
                || (req_span && !ALLOW_MISALIGNED);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      span_q  <= 1'b0;
      type_q  <= W;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= req_err;
        span_q  <= req_span;
        type_q  <= req_t;
        off_q   <= req_off;
        idx_q   <= req_idx[AW-1:0];
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACC1) hold_q <= ram_rdata;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACC0;
      ACC0:    state_d = (span_q && !err_q) ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  logic [31:0] lo_word, raw;
  always_comb begin
    ram_en    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = idx_q;
    ram_wdata = wdata_q << {off_q, 3'b000};
    case (state_q)
      ACC0: begin
        ram_en = !err_q && !rst;
        ram_be = we_q ? byte_strobe(type_q, off_q, 1'b0) : 4'h0;
      end
      ACC1: begin
        ram_en    = !rst;
        ram_addr  = idx_q + AW'(1);
        ram_be    = we_q ? byte_strobe(type_q, off_q, 1'b1) : 4'h0;
        ram_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
      end
      default: ;
    endcase

    lo_word = span_q ? hold_q : ram_rdata;
    raw     = 32'({ram_rdata, lo_word} >> {off_q, 3'b000});

    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) && err_q;
    bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? extend(type_q, raw) : 32'h0;
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk    (clk),
    .en_i   (ram_en),
    .be_i   (ram_be),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );
endmodule
